// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_pkg
// Desc     : Shared constants and counter-width helper for the button front-end
// Revision : 1.0  initial release
// ============================================================================
package btn_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int REPEAT_DELAY_DEF    = 50000000;
  localparam int REPEAT_PERIOD_DEF   = 10000000;

  localparam int CH_R   = 0;
  localparam int CH_L   = 1;
  localparam int NUM_CH = 2;

  // Width wide enough for the largest count, never narrower than one bit.
  function automatic int cntWidth(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Desc     : One button channel: 2-flop synchronizer, debounce counter,
//            debounced level and rising-edge detect
// Revision : 1.0  initial release
// ============================================================================
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = cntWidth(DEBOUNCE_CYCLES, 1, 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic btnRaw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_syncMeta;
  logic             r_sync;
  logic             r_level;
  logic             r_levelDly;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_syncMeta <= 1'b0;
      r_sync     <= 1'b0;
      r_level    <= 1'b0;
      r_levelDly <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_syncMeta <= btnRaw;
      r_sync     <= r_syncMeta;
      r_levelDly <= r_level;
      // Level only moves after DEBOUNCE_CYCLES consecutive differing samples.
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        r_level <= r_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_level & ~r_levelDly;

endmodule
`default_nettype wire

// File: rtl/btn_move_pulse.sv
`default_nettype none
// ============================================================================
// Module   : btn_move_pulse
// Desc     : Debounced, conflict-gated one-cycle move strobes for the LED bar.
//            Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses.
// Revision : 1.0  initial release
// ============================================================================
module btn_move_pulse
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btnR,
  input  logic btnL,
  output logic pulseR,
  output logic pulseL,
  output logic heldR,
  output logic heldL
);

  localparam int CNT_W = cntWidth(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  logic [NUM_CH-1:0] w_btnRaw;
  logic [NUM_CH-1:0] w_level;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_other;
  logic [NUM_CH-1:0] w_press;
  logic [NUM_CH-1:0] w_repeat;
  logic [NUM_CH-1:0] r_pulse;

  assign w_btnRaw[CH_R] = btnR;
  assign w_btnRaw[CH_L] = btnL;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .btnRaw(w_btnRaw[ch]),
      .level (w_level[ch]),
      .rise  (w_rise[ch])
    );
  end

  // A channel may only act while the opposite button is released.
  assign w_other[CH_R] = w_level[CH_L];
  assign w_other[CH_L] = w_level[CH_R];
  assign w_press       = w_rise & ~w_other;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] c_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_rep
    logic [CNT_W-1:0] r_repCnt;
    logic             r_armed;
    logic             r_periodic;
    logic             w_active;
    logic [CNT_W-1:0] w_limit;

    assign w_active     = w_level[ch] & ~w_other[ch];
    assign w_limit      = r_periodic ? c_PERIOD_LAST : c_DELAY_LAST;
    assign w_repeat[ch] = r_armed & w_active & (r_repCnt == w_limit);

    // Armed by the press pulse; any release or conflict disarms for good.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_repCnt   <= '0;
        r_armed    <= 1'b0;
        r_periodic <= 1'b0;
      end else if (!w_active) begin
        r_repCnt   <= '0;
        r_armed    <= 1'b0;
        r_periodic <= 1'b0;
      end else if (w_press[ch]) begin
        r_repCnt   <= '0;
        r_armed    <= 1'b1;
        r_periodic <= 1'b0;
      end else if (r_armed) begin
        if (w_repeat[ch]) begin
          r_repCnt   <= '0;
          r_periodic <= 1'b1;
        end else begin
          r_repCnt <= r_repCnt + 1'b1;
        end
      end
    end
  end
`else
  assign w_repeat = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pulse <= '0;
    end else begin
      r_pulse <= w_press | w_repeat;
    end
  end

  assign pulseR = r_pulse[CH_R];
  assign pulseL = r_pulse[CH_L];
  assign heldR  = w_level[CH_R];
  assign heldL  = w_level[CH_L];

endmodule
`default_nettype wire

// File: doc/btn_move_pulse.md
# btn_move_pulse

Button front-end that turns raw board push-buttons into clean one-cycle move commands for the LED position bar. Synchronizes, debounces and edge-detects the right and left buttons and emits single-cycle `pulseR` / `pulseL` strobes. The LED mover consumes these strobes as its shift commands. It sits between the board pins and the LED mover, on the same `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required before a debounced level changes (10 ms at 100 MHz); legal range ≥ 2
- `REPEAT_DELAY`, 50000000: cycles from first pulse to first auto-repeat pulse (auto-repeat build only)
- `REPEAT_PERIOD`, 10000000: cycles between subsequent auto-repeat pulses (auto-repeat build only)
- `clk`  input  1  system clock, all logic on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `btnR`  input  1  raw right button, asynchronous to `clk`
- `btnL`  input  1  raw left button, asynchronous to `clk`
- `pulseR`  output  1  one-cycle move-right strobe
- `pulseL`  output  1  one-cycle move-left strobe
- `heldR`  output  1  debounced right level
- `heldL`  output  1  debounced left level

## Operation
- Per channel: 2-flop synchronizer → debounce counter → debounced level → rising-edge detect.
- Debounce:
  - Counter clears whenever the synchronized value equals the debounced level.
  - Otherwise it increments. On reaching `DEBOUNCE_CYCLES-1` while still differing, the debounced level flips and the counter clears.
  - Any single-cycle glitch shorter than `DEBOUNCE_CYCLES` produces no level change.
- Release is debounced identically. Release never produces a pulse.
- Conflict rule:
  - A channel's pulse is suppressed if the other channel's debounced level is high in the same cycle.
  - Both levels rising in the same cycle → no pulse on either.
  - While both are held, neither channel pulses or repeats.
- Counter width: `$clog2` of the largest of the three parameters, with a minimum of 1 bit. No wrap. All counters saturate or clear as defined above.
- Reset:
  - All synchronizer flops, counters, levels and pulse registers go to 0, so every output is 0.
  - Reset asserted mid-debounce discards progress.
  - A button held through reset release is debounced from scratch and produces one pulse.

## Timing
- Raw change first sampled at edge 1; synchronized value valid after edge 2.
- Debounced level (`held*`) flips at edge `DEBOUNCE_CYCLES+2`.
- `pulse*` is registered: high for exactly the one cycle following edge `DEBOUNCE_CYCLES+3`.
- Total press latency is `DEBOUNCE_CYCLES+3` clocks.
- `pulse*` is never high on two consecutive cycles.
- Auto-repeat timing:
  - The repeat counter starts on the cycle the first pulse is emitted.
  - The first repeat pulse comes `REPEAT_DELAY` cycles after the first pulse.
  - Further repeats follow every `REPEAT_PERIOD` cycles while held.
  - Release, or a conflict, clears the repeat counter immediately.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - A held, non-conflicting button emits repeat pulses per the Timing rules.
  - `REPEAT_DELAY` and `REPEAT_PERIOD` are active.
- Undefined:
  - Exactly one pulse per debounced press.
  - Repeat counters are not instantiated; the repeat parameters are ignored.

## Structure
- Shared package `btn_pkg`:
  - default parameter constants `DEBOUNCE_CYCLES_DEF`, `REPEAT_DELAY_DEF`, `REPEAT_PERIOD_DEF`
  - channel index constants `CH_R` and `CH_L`
  - a counter-width function
- Sub-module `btn_debounce`: one channel covering synchronizer, debounce counter, level and edge detect. Instantiated twice.
- Top level `btn_move_pulse` contains the conflict gating, the optional repeat logic and the output registers.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=8`, `REPEAT_PERIOD=4`.
- Clean press: `btnR` 0→1 before edge 1 and held → `heldR`=1 after edge 6; `pulseR`=1 for exactly the cycle after edge 7; `pulseL` stays 0.
- Bounce: `btnL` toggles 1,0,1,0 on successive cycles, then stays 1 → no pulse during bouncing; one `pulseL` 7 cycles after the final stable rise.
- Glitch rejection: `btnR` high for 3 cycles, then low → `heldR` and `pulseR` stay 0 throughout.
- Conflict: `btnR` and `btnL` rise on the same edge and both held → `heldR`=`heldL`=1 and zero pulses. Release `btnL` → still no `pulseR`, because pulses fire only on press.
- Reset mid-operation: assert `rst` 2 cycles after `btnR` rises → all outputs 0 immediately. Deassert with `btnR` still held → single `pulseR` 7 cycles after the synchronizer first sees the button.
- Auto-repeat (`BTN_AUTOREPEAT_EN` defined): hold `btnR` for 30 cycles after its first pulse → repeats 8, 12, 16, 20, 24 and 28 cycles after the first pulse; release → no further pulses. Undefined build → exactly one pulse.
